from_local_xy: RTL and testbench
================================

# from_local_xy

2-D successor to the single-axis local injection unit. It sits between a neuron core's spike output and the mesh router. Each packet is steered into one of four per-direction FIFOs (east, west, north, south) using XY dimension-order routing on its signed dx and dy fields. Unlike the single-axis unit, it adds backpressure toward the core, per-channel occupancy counts, and saturating drop and error counters.

## Interface
- PACKET_WIDTH, 30, packet width in bits
- BUFFER_DEPTH, 4, entries per direction FIFO; power of 2, ≥ 2
- DX_MSB, 29, MSB of signed dx field
- DX_LSB, 21, LSB of signed dx field
- DY_MSB, 20, MSB of signed dy field
- DY_LSB, 12, LSB of signed dy field
- CNT_WIDTH, 16, width of drop/error counters
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- din  in  PACKET_WIDTH  packet from core
- din_wen  in  1  packet write strobe
- din_ready  out  1  target channel of current din can accept (combinational)
- ren  in  4  per-channel pop strobe; bit 0 E, 1 W, 2 N, 3 S
- dout  out  4*PACKET_WIDTH  head of each FIFO; channel i at [i*PACKET_WIDTH +: PACKET_WIDTH]
- empty  out  4  per-channel empty
- full  out  4  per-channel full
- count  out  4*(log2(BUFFER_DEPTH)+1)  per-channel occupancy, same slicing as dout
- drop_count  out  CNT_WIDTH  packets rejected because target FIFO full
- err_count  out  CNT_WIDTH  packets with dx==0 and dy==0

## Operation
- Target selection, from din fields as two's-complement:
  - dx>0 → E
  - dx<0 → W
  - dx==0 and dy>0 → N
  - dx==0 and dy<0 → S
  - dx==0 and dy==0 → no channel (error)
- din_ready = !full[target] for a valid target; 1 for an error packet, which is always consumed.
- Write: when din_wen and the target is valid and not full, din is pushed into the target FIFO unchanged.
- Overflow: when din_wen and the target is full, the packet is discarded, drop_count increments, and FIFO state is unchanged.
- Error packet: when din_wen with dx==0 and dy==0, the packet is discarded, err_count increments, and no FIFO changes.
- Counters: drop_count and err_count saturate at all-ones and never wrap.
- FIFO format: first-word-fall-through. dout slice shows the head entry whenever !empty. ren[i] pops at the edge.
- Underflow: ren[i] while empty[i] is ignored; pointers and count are unchanged.
- Full flag: full[i] uses state at the start of the cycle. A write to a full FIFO is rejected even if ren[i] pops that same cycle.
- Simultaneous write+pop on a non-empty, non-full FIFO: count unchanged; both pointers advance.
- Write to an empty FIFO with ren asserted: the write is accepted and the pop is ignored.
- Pointers: log2(BUFFER_DEPTH)-bit read/write pointers wrap modulo BUFFER_DEPTH.
  - count[i] = number of entries, range 0..BUFFER_DEPTH
  - empty[i] = (count==0)
  - full[i] = (count==BUFFER_DEPTH)
- Channels are fully independent; a full channel never blocks writes to the others.
- Reset values (any cycle, including mid-operation): all FIFOs flushed, pointers 0, storage 0, dout all 0, empty=4'b1111, full=0, count=0, drop_count=0, err_count=0.
  - In-flight din_wen on the reset edge is ignored and not counted.

## Timing
- Write latency: a packet written at edge k is visible on dout, with empty deasserted, in the cycle after edge k.
- Pop: ren at edge k exposes the next entry (or empty=1) after edge k.
- Status: full, count, and the counters update at the same edge as the causing write or pop.
- din_ready and target decode are purely combinational from din and current full; no registered path from din to din_ready.
- Throughput: one packet written per cycle, plus one pop per channel per cycle.

## Test plan
- Routing: after reset, write dx=+3, dx=-1, dx=0/dy=+2, dx=0/dy=-5 on consecutive cycles → empty=4'b0000, each count=1, each dout slice equals its packet, err_count=0.
- Fill/overflow (BUFFER_DEPTH=4): write 5 east packets A..E → full[0]=1 after the 4th, din_ready=0 for the 5th, drop_count=1; pop 4 → A,B,C,D in order, then empty[0]=1.
- Write+pop while full: with E full, a write with ren[0]=1 → pop accepted, write dropped, count=3, drop_count increments.
- Error path: write dx=0/dy=0 three times → err_count=3, all FIFOs empty, din_ready=1. Force err_count to all-ones → stays saturated on a further error.
- Wrap-around: 10 interleaved write/pop pairs on N with ≤2 entries resident → FIFO order preserved across pointer wrap; pop on empty N leaves count=0.
- Mid-operation reset: with W holding 3 entries and drop_count=2, assert reset for 1 cycle with din_wen high → all outputs return to reset values; the next write lands as the sole entry.

Source files
------------

// File: rtl/from_local_xy_if.sv
// from_local_xy_if: groups the core-side write port and the router-side
// per-direction FIFO ports of from_local_xy.
//   master: drives din, din_wen, ren (core + router side stimulus)
//   slave : drives din_ready, dout, empty, full, count, drop_count, err_count
// Channel order everywhere: 0 E, 1 W, 2 N, 3 S.
interface from_local_xy_if #(
  parameter int unsigned PACKET_WIDTH = 30,
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter int unsigned CNT_WIDTH    = 16
);
  localparam int unsigned CW = $clog2(BUFFER_DEPTH) + 1;

  logic [PACKET_WIDTH-1:0]   din;
  logic                      din_wen;
  logic                      din_ready;
  logic [3:0]                ren;
  logic [4*PACKET_WIDTH-1:0] dout;
  logic [3:0]                empty;
  logic [3:0]                full;
  logic [4*CW-1:0]           count;
  logic [CNT_WIDTH-1:0]      drop_count;
  logic [CNT_WIDTH-1:0]      err_count;

  modport master (
    output din, din_wen, ren,
    input  din_ready, dout, empty, full, count, drop_count, err_count
  );

  modport slave (
    input  din, din_wen, ren,
    output din_ready, dout, empty, full, count, drop_count, err_count
  );
endinterface

// File: rtl/from_local_xy.sv
// from_local_xy: 2-D local injection unit between a neuron core and the mesh
// router. Each packet is XY-routed on its signed dx/dy fields into one of four
// first-word-fall-through FIFOs (E, W, N, S).
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - from_local_xy_if.slave: din/din_wen/din_ready core write port,
//           ren/dout/empty/full/count per-channel FIFO ports,
//           drop_count (target full) and err_count (dx==dy==0), saturating.
module from_local_xy #(
  parameter int unsigned PACKET_WIDTH = 30,
  parameter int unsigned BUFFER_DEPTH = 4,
  parameter int unsigned DX_MSB       = 29,
  parameter int unsigned DX_LSB       = 21,
  parameter int unsigned DY_MSB       = 20,
  parameter int unsigned DY_LSB       = 12,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic            clk,
  input  logic            reset,
  from_local_xy_if.slave  bus
);
  localparam int unsigned PW  = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned NCH = 4;

  logic [PACKET_WIDTH-1:0] mem_q [NCH][BUFFER_DEPTH];
  logic [PACKET_WIDTH-1:0] mem_d [NCH][BUFFER_DEPTH];
  logic [PW-1:0]           wr_ptr_q [NCH];
  logic [PW-1:0]           wr_ptr_d [NCH];
  logic [PW-1:0]           rd_ptr_q [NCH];
  logic [PW-1:0]           rd_ptr_d [NCH];
  logic [CW-1:0]           cnt_q [NCH];
  logic [CW-1:0]           cnt_d [NCH];
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;
  logic [CNT_WIDTH-1:0]    err_q, err_d;

  logic [DX_MSB-DX_LSB:0]  dx;
  logic [DY_MSB-DY_LSB:0]  dy;
  logic [NCH-1:0]          tgt;
  logic                    is_err;
  logic [NCH-1:0]          full_v;
  logic [NCH-1:0]          empty_v;
  logic [NCH-1:0]          push;
  logic [NCH-1:0]          pop;

  // XY decode: X resolved first; Y only when dx==0.
  always_comb begin
    dx     = bus.din[DX_MSB:DX_LSB];
    dy     = bus.din[DY_MSB:DY_LSB];
    tgt    = '0;
    is_err = 1'b0;
    if (dx != '0) begin
      if (dx[DX_MSB-DX_LSB]) tgt[1] = 1'b1;
      else                   tgt[0] = 1'b1;
    end else if (dy != '0) begin
      if (dy[DY_MSB-DY_LSB]) tgt[3] = 1'b1;
      else                   tgt[2] = 1'b1;
    end else begin
      is_err = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      full_v[i]  = (cnt_q[i] == CW'(BUFFER_DEPTH));
      empty_v[i] = (cnt_q[i] == '0);
    end
  end

  // Error packets are always consumed, so they never stall the core.
  always_comb begin
    bus.din_ready = is_err | (|(tgt & ~full_v));
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    err_d    = err_q;
    push     = '0;
    pop      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // full/empty come from start-of-cycle state: a pop never makes room for
      // a same-cycle write, and a write never feeds a same-cycle pop.
      push[i] = bus.din_wen & tgt[i] & ~full_v[i];
      pop[i]  = bus.ren[i] & ~empty_v[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.din;
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
    if (bus.din_wen && !is_err && (|(tgt & full_v)) && (drop_q != '1))
      drop_d = drop_q + CNT_WIDTH'(1);
    if (bus.din_wen && is_err && (err_q != '1))
      err_d = err_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        for (int unsigned j = 0; j < BUFFER_DEPTH; j++) mem_q[i][j] <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      drop_q <= '0;
      err_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.dout[i*PACKET_WIDTH +: PACKET_WIDTH] = mem_q[i][rd_ptr_q[i]];
      bus.count[i*CW +: CW]                    = cnt_q[i];
    end
    bus.empty      = empty_v;
    bus.full       = full_v;
    bus.drop_count = drop_q;
    bus.err_count  = err_q;
  end
endmodule

// File: tb/tb_from_local_xy.sv
module tb_from_local_xy;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  from_local_xy_if #(.PACKET_WIDTH(30), .BUFFER_DEPTH(4), .CNT_WIDTH(16)) bus ();
  from_local_xy_if #(.PACKET_WIDTH(30), .BUFFER_DEPTH(2), .CNT_WIDTH(2))  bus2 ();

  from_local_xy #(
    .PACKET_WIDTH(30), .BUFFER_DEPTH(4), .DX_MSB(29), .DX_LSB(21),
    .DY_MSB(20), .DY_LSB(12), .CNT_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Small instance for counter saturation at a reachable width.
  from_local_xy #(
    .PACKET_WIDTH(30), .BUFFER_DEPTH(2), .DX_MSB(29), .DX_LSB(21),
    .DY_MSB(20), .DY_LSB(12), .CNT_WIDTH(2)
  ) dut_small (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] pkt(input int dx, input int dy, input logic [11:0] pl);
    logic [8:0] x;
    logic [8:0] y;
    x = 9'(dx);
    y = 9'(dy);
    return {x, y, pl};
  endfunction

  task automatic cyc(input logic [29:0] d, input logic wen, input logic [3:0] r);
    bus.din     = d;
    bus.din_wen = wen;
    bus.ren     = r;
    @(posedge clk);
    #1;
    bus.din_wen = 1'b0;
    bus.ren     = 4'b0000;
  endtask

  task automatic cyc2(input logic [29:0] d, input logic wen, input logic [3:0] r);
    bus2.din     = d;
    bus2.din_wen = wen;
    bus2.ren     = r;
    @(posedge clk);
    #1;
    bus2.din_wen = 1'b0;
    bus2.ren     = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b want %b", bus.empty, 4'b1111); end
    checks++; if (bus.full !== 4'b0000) begin errors++; $display("FAIL reset_full got %b want %b", bus.full, 4'b0000); end
    checks++; if (bus.count !== 12'h000) begin errors++; $display("FAIL reset_count got %h want %h", bus.count, 12'h000); end
    checks++; if (bus.dout !== 120'h0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.dout); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", bus.err_count); end
    bus.din = pkt(1, 0, 12'h001);
    #1;
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.din_ready); end
  endtask

  task automatic test_routing();
    logic [29:0] pe, pw, pn, ps;
    do_reset();
    pe = pkt(3, 7, 12'h111);
    pw = pkt(-1, -4, 12'h222);
    pn = pkt(0, 2, 12'h333);
    ps = pkt(0, -5, 12'h444);
    cyc(pe, 1'b1, 4'b0000);
    checks++; if (bus.empty !== 4'b1110) begin errors++; $display("FAIL route_latency_empty got %b want %b", bus.empty, 4'b1110); end
    cyc(pw, 1'b1, 4'b0000);
    cyc(pn, 1'b1, 4'b0000);
    cyc(ps, 1'b1, 4'b0000);
    checks++; if (bus.empty !== 4'b0000) begin errors++; $display("FAIL route_empty got %b want %b", bus.empty, 4'b0000); end
    checks++; if (bus.count !== {3'd1, 3'd1, 3'd1, 3'd1}) begin errors++; $display("FAIL route_count got %h want %h", bus.count, {3'd1, 3'd1, 3'd1, 3'd1}); end
    checks++; if (bus.dout[0 +: 30] !== pe) begin errors++; $display("FAIL route_e got %h want %h", bus.dout[0 +: 30], pe); end
    checks++; if (bus.dout[30 +: 30] !== pw) begin errors++; $display("FAIL route_w got %h want %h", bus.dout[30 +: 30], pw); end
    checks++; if (bus.dout[60 +: 30] !== pn) begin errors++; $display("FAIL route_n got %h want %h", bus.dout[60 +: 30], pn); end
    checks++; if (bus.dout[90 +: 30] !== ps) begin errors++; $display("FAIL route_s got %h want %h", bus.dout[90 +: 30], ps); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL route_err got %0d want 0", bus.err_count); end
    cyc(30'h0, 1'b0, 4'b1111);
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL route_popall got %b want %b", bus.empty, 4'b1111); end
  endtask

  task automatic test_fill_overflow();
    logic [29:0] p [5];
    logic [29:0] f, g;
    do_reset();
    for (int k = 0; k < 5; k++) p[k] = pkt(1 + k, 0, 12'hA00 + 12'(k));
    for (int k = 0; k < 4; k++) cyc(p[k], 1'b1, 4'b0000);
    checks++; if (bus.full !== 4'b0001) begin errors++; $display("FAIL fill_full got %b want %b", bus.full, 4'b0001); end
    checks++; if (bus.count[0 +: 3] !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count[0 +: 3]); end
    bus.din = p[4];
    #1;
    checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_e got %b want 0", bus.din_ready); end
    bus.din = pkt(0, 1, 12'h000);
    #1;
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_n got %b want 1", bus.din_ready); end
    cyc(p[4], 1'b1, 4'b0000);
    checks++; if (bus.drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", bus.drop_count); end
    checks++; if (bus.count[0 +: 3] !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", bus.count[0 +: 3]); end
    checks++; if (bus.dout[0 +: 30] !== p[0]) begin errors++; $display("FAIL ovf_head got %h want %h", bus.dout[0 +: 30], p[0]); end
    // Write with pop while full: pop of A taken, write dropped.
    f = pkt(9, 0, 12'hF0F);
    cyc(f, 1'b1, 4'b0001);
    checks++; if (bus.count[0 +: 3] !== 3'd3) begin errors++; $display("FAIL wpfull_count got %0d want 3", bus.count[0 +: 3]); end
    checks++; if (bus.drop_count !== 16'd2) begin errors++; $display("FAIL wpfull_drop got %0d want 2", bus.drop_count); end
    checks++; if (bus.full[0] !== 1'b0) begin errors++; $display("FAIL wpfull_full got %b want 0", bus.full[0]); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (bus.dout[0 +: 30] !== p[k]) begin errors++; $display("FAIL pop_order%0d got %h want %h", k, bus.dout[0 +: 30], p[k]); end
      cyc(30'h0, 1'b0, 4'b0001);
    end
    checks++; if (bus.empty[0] !== 1'b1) begin errors++; $display("FAIL pop_empty got %b want 1", bus.empty[0]); end
    // Write into empty FIFO with pop: write accepted, pop ignored.
    g = pkt(2, 0, 12'h5A5);
    cyc(g, 1'b1, 4'b0001);
    checks++; if (bus.count[0 +: 3] !== 3'd1) begin errors++; $display("FAIL wempty_count got %0d want 1", bus.count[0 +: 3]); end
    checks++; if (bus.dout[0 +: 30] !== g) begin errors++; $display("FAIL wempty_head got %h want %h", bus.dout[0 +: 30], g); end
  endtask

  task automatic test_error();
    logic [29:0] pz;
    do_reset();
    pz = pkt(0, 0, 12'hEEE);
    bus.din = pz;
    #1;
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", bus.din_ready); end
    for (int k = 0; k < 3; k++) cyc(pz, 1'b1, 4'b0000);
    checks++; if (bus.err_count !== 16'd3) begin errors++; $display("FAIL err_count got %0d want 3", bus.err_count); end
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL err_empty got %b want %b", bus.empty, 4'b1111); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL err_drop got %0d want 0", bus.drop_count); end
  endtask

  task automatic test_saturation();
    logic [29:0] pz;
    pz = pkt(0, 0, 12'h000);
    for (int k = 0; k < 3; k++) cyc2(pz, 1'b1, 4'b0000);
    checks++; if (bus2.err_count !== 2'd3) begin errors++; $display("FAIL sat_err_max got %0d want 3", bus2.err_count); end
    cyc2(pz, 1'b1, 4'b0000);
    checks++; if (bus2.err_count !== 2'd3) begin errors++; $display("FAIL sat_err_hold got %0d want 3", bus2.err_count); end
    for (int k = 0; k < 2; k++) cyc2(pkt(1, 0, 12'(k)), 1'b1, 4'b0000);
    checks++; if (bus2.full !== 4'b0001) begin errors++; $display("FAIL sat_full got %b want %b", bus2.full, 4'b0001); end
    for (int k = 0; k < 3; k++) cyc2(pkt(1, 0, 12'hD00), 1'b1, 4'b0000);
    checks++; if (bus2.drop_count !== 2'd3) begin errors++; $display("FAIL sat_drop_max got %0d want 3", bus2.drop_count); end
    cyc2(pkt(1, 0, 12'hD01), 1'b1, 4'b0000);
    checks++; if (bus2.drop_count !== 2'd3) begin errors++; $display("FAIL sat_drop_hold got %0d want 3", bus2.drop_count); end
    checks++; if (bus2.count[0 +: 2] !== 2'd2) begin errors++; $display("FAIL sat_count got %0d want 2", bus2.count[0 +: 2]); end
  endtask

  task automatic test_wrap();
    logic [29:0] p [10];
    do_reset();
    for (int k = 0; k < 10; k++) p[k] = pkt(0, 3, 12'hC00 + 12'(k));
    cyc(p[0], 1'b1, 4'b0000);
    for (int k = 1; k < 10; k++) begin
      checks++; if (bus.dout[60 +: 30] !== p[k-1]) begin errors++; $display("FAIL wrap_head%0d got %h want %h", k - 1, bus.dout[60 +: 30], p[k-1]); end
      cyc(p[k], 1'b1, 4'b0100);
      checks++; if (bus.count[6 +: 3] !== 3'd1) begin errors++; $display("FAIL wrap_count%0d got %0d want 1", k, bus.count[6 +: 3]); end
    end
    checks++; if (bus.dout[60 +: 30] !== p[9]) begin errors++; $display("FAIL wrap_head9 got %h want %h", bus.dout[60 +: 30], p[9]); end
    cyc(30'h0, 1'b0, 4'b0100);
    checks++; if (bus.empty[2] !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", bus.empty[2]); end
    cyc(30'h0, 1'b0, 4'b0100);
    checks++; if (bus.count[6 +: 3] !== 3'd0) begin errors++; $display("FAIL underflow_count got %0d want 0", bus.count[6 +: 3]); end
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL underflow_empty got %b want %b", bus.empty, 4'b1111); end
  endtask

  task automatic test_mid_reset();
    logic [29:0] pnew;
    do_reset();
    for (int k = 0; k < 6; k++) cyc(pkt(5, 0, 12'(k)), 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) cyc(pkt(-2, 1, 12'hB00 + 12'(k)), 1'b1, 4'b0000);
    checks++; if (bus.count[3 +: 3] !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", bus.count[3 +: 3]); end
    checks++; if (bus.drop_count !== 16'd2) begin errors++; $display("FAIL mid_pre_drop got %0d want 2", bus.drop_count); end
    reset       = 1'b1;
    bus.din     = pkt(-2, 1, 12'hBAD);
    bus.din_wen = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.din_wen = 1'b0;
    checks++; if (bus.empty !== 4'b1111) begin errors++; $display("FAIL mid_empty got %b want %b", bus.empty, 4'b1111); end
    checks++; if (bus.full !== 4'b0000) begin errors++; $display("FAIL mid_full got %b want %b", bus.full, 4'b0000); end
    checks++; if (bus.count !== 12'h000) begin errors++; $display("FAIL mid_count got %h want 000", bus.count); end
    checks++; if (bus.dout !== 120'h0) begin errors++; $display("FAIL mid_dout got %h want 0", bus.dout); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", bus.drop_count); end
    checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL mid_err got %0d want 0", bus.err_count); end
    pnew = pkt(-7, 0, 12'h777);
    cyc(pnew, 1'b1, 4'b0000);
    checks++; if (bus.count[3 +: 3] !== 3'd1) begin errors++; $display("FAIL mid_next_count got %0d want 1", bus.count[3 +: 3]); end
    checks++; if (bus.dout[30 +: 30] !== pnew) begin errors++; $display("FAIL mid_next_head got %h want %h", bus.dout[30 +: 30], pnew); end
    checks++; if (bus.empty !== 4'b1101) begin errors++; $display("FAIL mid_next_empty got %b want %b", bus.empty, 4'b1101); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.din      = '0;
    bus.din_wen  = 1'b0;
    bus.ren      = 4'b0000;
    bus2.din     = '0;
    bus2.din_wen = 1'b0;
    bus2.ren     = 4'b0000;
    test_reset();
    test_routing();
    test_fill_overflow();
    test_error();
    test_saturation();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
